nes_frame_writer: RTL

- Write side of the NES frame path, and the supplier of `rgb_buf` to the VGA output driver.
- Accepts the PPU pixel stream, 9-bit RGB in raster order, through a valid/ready handshake.
- Stores pixels in a double-buffered 256x240 frame memory.
- The VGA driver reads the front bank by `pix_ptr_x` / `pix_ptr_y`. Banks swap only at VGA vertical sync, so the display never shows a partial frame.

---
 rtl/nes_frame_writer.sv | 85 ++++++++
 1 files changed

// File: rtl/nes_frame_writer.sv
// nes_frame_writer: double-buffered NES frame store, written from the PPU pixel stream and read by the VGA driver.
module nes_frame_writer #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 240,
  parameter int RGB_W  = 9
) (
  input  logic             pix_clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RGB_W-1:0] in_rgb,
  input  logic             in_sof,
  input  logic [7:0]       pix_ptr_x,
  input  logic [7:0]       pix_ptr_y,
  input  logic             reading,
  input  logic             vsync,
  output logic [RGB_W-1:0] rgb_buf,
  output logic             frame_ready,
  output logic [7:0]       frames_done,
  output logic             sync_err
);
  localparam int XW = $clog2(WIDTH);
  localparam logic [1:0] WAIT_SOF = 2'd0;
  localparam logic [1:0] WRITE    = 2'd1;
  localparam logic [1:0] FULL     = 2'd2;
  logic [1:0]       state;
  logic [XW-1:0]    x;
  logic [7:0]       y;
  logic             front;
  logic             vs_q;
  logic             accept;
  logic             we;
  logic             last;
  logic             fall;
  logic [XW+8:0]    wr_addr;
  logic [RGB_W-1:0] mem [0:(1<<(XW+9))-1];
  assign in_ready = reset_n && state != FULL;
  assign accept   = in_valid && in_ready;
  assign we       = accept && (in_sof || state == WRITE);
  assign last     = x == XW'(WIDTH - 1) && y == 8'(HEIGHT - 1);
  assign fall     = vs_q && !vsync;
  // an sof beat always lands at (0,0), whether it starts or restarts a frame
  assign wr_addr  = in_sof ? {~front, {(XW+8){1'b0}}} : {~front, y, x};
  always_ff @(posedge pix_clk)
    if (we) mem[wr_addr] <= in_rgb;
  always_ff @(posedge pix_clk or negedge reset_n)
    if (!reset_n) begin
      state       <= WAIT_SOF;
      x           <= '0;
      y           <= '0;
      front       <= 1'b0;
      vs_q        <= 1'b1;
      frame_ready <= 1'b0;
      frames_done <= '0;
      sync_err    <= 1'b0;
      rgb_buf     <= '0;
    end else begin
      vs_q <= vsync;
      if (reading)
        rgb_buf <= {1'b0, pix_ptr_y} >= 9'(HEIGHT) ? '0 : mem[{front, pix_ptr_y, pix_ptr_x[XW-1:0]}];
      if (state == FULL) begin
        if (fall) begin
          front       <= ~front;
          frame_ready <= 1'b0;
          frames_done <= frames_done + 1'b1;
          state       <= WAIT_SOF;
        end
      end else if (accept && in_sof) begin
        if (state == WRITE) sync_err <= 1'b1;
        x     <= XW'(1);
        y     <= '0;
        state <= WRITE;
      end else if (accept && state == WRITE) begin
        if (last) begin
          state       <= FULL;
          frame_ready <= 1'b1;
          x           <= '0;
          y           <= '0;
        end else begin
          x <= x + 1'b1;
          if (x == XW'(WIDTH - 1)) y <= y + 1'b1;
        end
      end
    end
endmodule
